except_req_gen: RTL and testbench

//  Exception/interrupt request generator at the commit (MEM->WB) boundary of the dual-issue pipeline.

---
 rtl/except_req_gen.sv | 168 ++++++++++++++++
 tb/tb_except_req_gen.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/except_req_gen.sv
// Commit-stage exception/interrupt request generator for the dual-issue pipeline.
// Picks the oldest event across both lanes and emits registered requests to the controller and CSR file.
module except_req_gen #(
    parameter int ADDR_W       = 32,
    parameter int INT_W        = 13,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lane1_valid,
    input  logic [ADDR_W-1:0] lane1_pc,
    input  logic              lane1_sys,
    input  logic              lane1_brk,
    input  logic              lane1_idle,
    input  logic              lane2_valid,
    input  logic [ADDR_W-1:0] lane2_pc,
    input  logic              lane2_sys,
    input  logic              lane2_brk,
    input  logic              lane2_idle,
    input  logic [INT_W-1:0]  int_pending,
    input  logic [INT_W-1:0]  int_mask,
    input  logic              int_enable,
    input  logic              pipe_busy,
    output logic [1:0]        excepttype_o_1,
    output logic [1:0]        excepttype_o_2,
    output logic              idle_stallreq,
    output logic              has_int_stallreq,
    output logic              era_we,
    output logic [ADDR_W-1:0] era_o,
    output logic [5:0]        ecode_o
);

    typedef enum logic [1:0] {
        RUN,
        INT_DRAIN,
        IDLE,
        FLUSH
    } state_t;

    localparam logic [1:0] TYPE_NONE = 2'b00;
    localparam logic [1:0] TYPE_SYNC = 2'b01;
    localparam logic [1:0] TYPE_INT  = 2'b10;
    localparam logic [5:0] ECODE_INT = 6'h00;
    localparam logic [5:0] ECODE_SYS = 6'h0B;
    localparam logic [5:0] ECODE_BRK = 6'h0C;
    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t            state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic [1:0]        type1_nxt, type2_nxt;
    logic              we_nxt;
    logic [ADDR_W-1:0] era_nxt;
    logic [5:0]        ecode_nxt;

    logic wake, pend;
    logic sync1, sync2, idle1, idle2;

    assign wake  = |(int_pending & int_mask);
    assign pend  = wake & int_enable;
    assign sync1 = lane1_valid & (lane1_sys | lane1_brk);
    assign sync2 = lane2_valid & (lane2_sys | lane2_brk);
    assign idle1 = lane1_valid & lane1_idle;
    assign idle2 = lane2_valid & lane2_idle;

    // Next-state and next-output decode; everything lands in registers below.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        type1_nxt = TYPE_NONE;
        type2_nxt = TYPE_NONE;
        we_nxt    = 1'b0;
        era_nxt   = era_o;
        ecode_nxt = ecode_o;

        case (state)
            RUN: begin
                if (sync1) begin
                    type1_nxt = TYPE_SYNC;
                    we_nxt    = 1'b1;
                    era_nxt   = lane1_pc;
                    ecode_nxt = lane1_sys ? ECODE_SYS : ECODE_BRK;
                    state_nxt = FLUSH;
                    cnt_nxt   = FLUSH_LOAD;
                end else if (idle1) begin
                    era_nxt   = lane1_pc + ADDR_W'(4);
                    state_nxt = IDLE;
                end else if (sync2) begin
                    type2_nxt = TYPE_SYNC;
                    we_nxt    = 1'b1;
                    era_nxt   = lane2_pc;
                    ecode_nxt = lane2_sys ? ECODE_SYS : ECODE_BRK;
                    state_nxt = FLUSH;
                    cnt_nxt   = FLUSH_LOAD;
                end else if (idle2) begin
                    era_nxt   = lane2_pc + ADDR_W'(4);
                    state_nxt = IDLE;
                end else if (pend) begin
                    state_nxt = INT_DRAIN;
                end
            end
            INT_DRAIN: begin
                if (sync1) begin
                    type1_nxt = TYPE_SYNC;
                    we_nxt    = 1'b1;
                    era_nxt   = lane1_pc;
                    ecode_nxt = lane1_sys ? ECODE_SYS : ECODE_BRK;
                    state_nxt = FLUSH;
                    cnt_nxt   = FLUSH_LOAD;
                end else if (!pend) begin
                    state_nxt = RUN;
                end else if (!pipe_busy && lane1_valid) begin
                    type1_nxt = TYPE_INT;
                    we_nxt    = 1'b1;
                    era_nxt   = lane1_pc;
                    ecode_nxt = ECODE_INT;
                    state_nxt = FLUSH;
                    cnt_nxt   = FLUSH_LOAD;
                end
            end
            IDLE: begin
                // era_o already holds the idle return address captured on entry.
                if (wake) begin
                    type1_nxt = TYPE_INT;
                    we_nxt    = 1'b1;
                    ecode_nxt = ECODE_INT;
                    state_nxt = FLUSH;
                    cnt_nxt   = FLUSH_LOAD;
                end
            end
            FLUSH: begin
                if (cnt == 4'd0) begin
                    state_nxt = RUN;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    // State and registered outputs; stall requests mirror the state being entered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= RUN;
            cnt              <= 4'd0;
            excepttype_o_1   <= TYPE_NONE;
            excepttype_o_2   <= TYPE_NONE;
            idle_stallreq    <= 1'b0;
            has_int_stallreq <= 1'b0;
            era_we           <= 1'b0;
            era_o            <= '0;
            ecode_o          <= 6'h00;
        end else begin
            state            <= state_nxt;
            cnt              <= cnt_nxt;
            excepttype_o_1   <= type1_nxt;
            excepttype_o_2   <= type2_nxt;
            idle_stallreq    <= (state_nxt == IDLE);
            has_int_stallreq <= (state_nxt == INT_DRAIN);
            era_we           <= we_nxt;
            era_o            <= era_nxt;
            ecode_o          <= ecode_nxt;
        end
    end

endmodule

// File: tb/tb_except_req_gen.sv
// Directed self-checking bench for except_req_gen (FLUSH_CYCLES = 2).
module tb_except_req_gen;

    logic        clk;
    logic        rst_n;
    logic        lane1_valid, lane1_sys, lane1_brk, lane1_idle;
    logic        lane2_valid, lane2_sys, lane2_brk, lane2_idle;
    logic [31:0] lane1_pc, lane2_pc;
    logic [12:0] int_pending, int_mask;
    logic        int_enable, pipe_busy;
    logic [1:0]  type1, type2;
    logic        idle_stallreq, has_int_stallreq, era_we;
    logic [31:0] era_o;
    logic [5:0]  ecode_o;

    int passed = 0;
    int total  = 0;

    except_req_gen #(.ADDR_W(32), .INT_W(13), .FLUSH_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .lane1_valid(lane1_valid), .lane1_pc(lane1_pc), .lane1_sys(lane1_sys),
        .lane1_brk(lane1_brk), .lane1_idle(lane1_idle),
        .lane2_valid(lane2_valid), .lane2_pc(lane2_pc), .lane2_sys(lane2_sys),
        .lane2_brk(lane2_brk), .lane2_idle(lane2_idle),
        .int_pending(int_pending), .int_mask(int_mask), .int_enable(int_enable),
        .pipe_busy(pipe_busy),
        .excepttype_o_1(type1), .excepttype_o_2(type2),
        .idle_stallreq(idle_stallreq), .has_int_stallreq(has_int_stallreq),
        .era_we(era_we), .era_o(era_o), .ecode_o(ecode_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge before checks.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        lane1_valid = 0; lane1_sys = 0; lane1_brk = 0; lane1_idle = 0; lane1_pc = '0;
        lane2_valid = 0; lane2_sys = 0; lane2_brk = 0; lane2_idle = 0; lane2_pc = '0;
        int_pending = '0; int_mask = '0; int_enable = 0; pipe_busy = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 0;
        step();
        rst_n = 1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        step();
        step();
        total++; if (type1 !== 2'b00) $display("FAIL reset_type1 got %b exp 00", type1); else passed++;
        total++; if (type2 !== 2'b00) $display("FAIL reset_type2 got %b exp 00", type2); else passed++;
        total++; if ({idle_stallreq, has_int_stallreq, era_we} !== 3'b000)
            $display("FAIL reset_flags got %b exp 000", {idle_stallreq, has_int_stallreq, era_we}); else passed++;
        total++; if (era_o !== 32'h0) $display("FAIL reset_era got %h exp 00000000", era_o); else passed++;
        total++; if (ecode_o !== 6'h00) $display("FAIL reset_ecode got %h exp 00", ecode_o); else passed++;
        rst_n = 1;
    endtask

    task automatic test_lane1_sys();
        do_reset();
        lane1_valid = 1; lane1_sys = 1; lane1_pc = 32'h1C000100;
        step();
        clear_inputs();
        total++; if (type1 !== 2'b01) $display("FAIL sys_type1 got %b exp 01", type1); else passed++;
        total++; if (type2 !== 2'b00) $display("FAIL sys_type2 got %b exp 00", type2); else passed++;
        total++; if (era_o !== 32'h1C000100) $display("FAIL sys_era got %h exp 1c000100", era_o); else passed++;
        total++; if (ecode_o !== 6'h0B) $display("FAIL sys_ecode got %h exp 0b", ecode_o); else passed++;
        total++; if (era_we !== 1'b1) $display("FAIL sys_we got %b exp 1", era_we); else passed++;
        step();
        total++; if ({era_we, type1} !== 3'b000) $display("FAIL sys_pulse_end got %b exp 000", {era_we, type1}); else passed++;
    endtask

    task automatic test_brk_vs_lane2();
        do_reset();
        lane1_valid = 1; lane1_brk = 1; lane1_pc = 32'h100;
        lane2_valid = 1; lane2_sys = 1; lane2_pc = 32'h104;
        step();
        clear_inputs();
        total++; if (type1 !== 2'b01) $display("FAIL brk_type1 got %b exp 01", type1); else passed++;
        total++; if (type2 !== 2'b00) $display("FAIL brk_type2 got %b exp 00", type2); else passed++;
        total++; if (ecode_o !== 6'h0C) $display("FAIL brk_ecode got %h exp 0c", ecode_o); else passed++;
        total++; if (era_o !== 32'h100) $display("FAIL brk_era got %h exp 00000100", era_o); else passed++;
    endtask

    task automatic test_lane2_sys();
        do_reset();
        lane1_valid = 1; lane1_pc = 32'h204;
        lane2_valid = 1; lane2_sys = 1; lane2_brk = 1; lane2_pc = 32'h208;
        step();
        clear_inputs();
        total++; if ({type1, type2} !== 4'b0001) $display("FAIL l2sys_types got %b exp 0001", {type1, type2}); else passed++;
        total++; if (ecode_o !== 6'h0B) $display("FAIL l2sys_ecode got %h exp 0b", ecode_o); else passed++;
        total++; if (era_o !== 32'h208) $display("FAIL l2sys_era got %h exp 00000208", era_o); else passed++;
        total++; if (era_we !== 1'b1) $display("FAIL l2sys_we got %b exp 1", era_we); else passed++;
    endtask

    task automatic test_flush_ignore();
        do_reset();
        lane1_valid = 1; lane1_sys = 1; lane1_pc = 32'h300;
        step();
        lane1_pc = 32'h340;
        for (int i = 0; i < 2; i++) begin
            step();
            total++; if ({type1, type2, era_we} !== 5'b00000)
                $display("FAIL flush_ignore%0d got %b exp 00000", i, {type1, type2, era_we}); else passed++;
        end
        step();
        clear_inputs();
        total++; if ({type1, era_o} !== {2'b01, 32'h340})
            $display("FAIL post_flush_sys got %b/%h exp 01/00000340", type1, era_o); else passed++;
    endtask

    task automatic test_int_drain();
        do_reset();
        int_enable = 1; int_mask[3] = 1; int_pending[3] = 1; pipe_busy = 1;
        step();
        total++; if (has_int_stallreq !== 1'b1) $display("FAIL drain_enter got %b exp 1", has_int_stallreq); else passed++;
        lane1_valid = 1; lane1_pc = 32'h1F0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if ({has_int_stallreq, type1, era_we} !== 4'b1000)
                $display("FAIL drain_busy%0d got %b exp 1000", i, {has_int_stallreq, type1, era_we}); else passed++;
        end
        pipe_busy = 0; lane1_pc = 32'h200;
        step();
        clear_inputs();
        total++; if (type1 !== 2'b10) $display("FAIL int_type1 got %b exp 10", type1); else passed++;
        total++; if (era_o !== 32'h200) $display("FAIL int_era got %h exp 00000200", era_o); else passed++;
        total++; if ({ecode_o, era_we, has_int_stallreq} !== {6'h00, 1'b1, 1'b0})
            $display("FAIL int_ecode_we got %h/%b/%b exp 00/1/0", ecode_o, era_we, has_int_stallreq); else passed++;
    endtask

    task automatic test_drain_abort_and_sync();
        do_reset();
        int_enable = 1; int_mask[0] = 1; int_pending[0] = 1;
        step();
        int_pending[0] = 0;
        step();
        total++; if ({has_int_stallreq, type1} !== 3'b000)
            $display("FAIL drain_abort got %b exp 000", {has_int_stallreq, type1}); else passed++;
        int_pending[0] = 1;
        step();
        lane1_valid = 1; lane1_sys = 1; lane1_pc = 32'h500; pipe_busy = 1;
        step();
        clear_inputs();
        total++; if ({type1, has_int_stallreq, ecode_o} !== {2'b01, 1'b0, 6'h0B})
            $display("FAIL drain_sync got %b/%b/%h exp 01/0/0b", type1, has_int_stallreq, ecode_o); else passed++;
    endtask

    task automatic test_idle_wake();
        do_reset();
        lane1_valid = 1; lane1_pc = 32'h3F8;
        lane2_valid = 1; lane2_idle = 1; lane2_pc = 32'h3FC;
        step();
        total++; if ({idle_stallreq, era_we} !== 2'b10) $display("FAIL idle_enter got %b exp 10", {idle_stallreq, era_we}); else passed++;
        total++; if (era_o !== 32'h400) $display("FAIL idle_era got %h exp 00000400", era_o); else passed++;
        lane1_sys = 1; lane1_pc = 32'h9000;
        step();
        total++; if ({idle_stallreq, type1} !== 3'b100) $display("FAIL idle_hold got %b exp 100", {idle_stallreq, type1}); else passed++;
        int_pending[2] = 1; int_mask[2] = 1;
        step();
        clear_inputs();
        total++; if ({type1, type2} !== 4'b1000) $display("FAIL wake_types got %b exp 1000", {type1, type2}); else passed++;
        total++; if ({era_o, ecode_o} !== {32'h400, 6'h00}) $display("FAIL wake_era got %h/%h exp 00000400/00", era_o, ecode_o); else passed++;
        total++; if ({era_we, idle_stallreq} !== 2'b10) $display("FAIL wake_flags got %b exp 10", {era_we, idle_stallreq}); else passed++;
    endtask

    task automatic test_idle_wrap();
        do_reset();
        lane1_valid = 1; lane1_idle = 1; lane1_pc = 32'hFFFFFFFC;
        step();
        clear_inputs();
        total++; if ({idle_stallreq, era_o} !== {1'b1, 32'h0})
            $display("FAIL idle_wrap got %b/%h exp 1/00000000", idle_stallreq, era_o); else passed++;
    endtask

    task automatic test_reset_in_drain();
        do_reset();
        int_enable = 1; int_mask[5] = 1; int_pending[5] = 1; pipe_busy = 1;
        lane1_valid = 1; lane1_pc = 32'h700;
        step();
        step();
        rst_n = 0;
        step();
        total++; if ({type1, type2, idle_stallreq, has_int_stallreq, era_we, era_o, ecode_o} !== '0)
            $display("FAIL rst_drain got %b/%b/%b/%b/%b/%h/%h exp all 0",
                     type1, type2, idle_stallreq, has_int_stallreq, era_we, era_o, ecode_o); else passed++;
        rst_n = 1; pipe_busy = 0;
        step();
        clear_inputs();
        total++; if (has_int_stallreq !== 1'b1) $display("FAIL rst_drain_restart got %b exp 1", has_int_stallreq); else passed++;
    endtask

    initial begin
        clear_inputs();
        rst_n = 0;
        test_reset();
        test_lane1_sys();
        test_brk_vs_lane2();
        test_lane2_sys();
        test_flush_ignore();
        test_int_drain();
        test_drain_abort_and_sync();
        test_idle_wake();
        test_idle_wrap();
        test_reset_in_drain();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
